// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the pipeline controller: stall encodings, divider
// sequencer states and the stall priority encoder.
package pipe_ctrl_pkg;

    localparam logic STOP   = 1'b1;
    localparam logic NOSTOP = 1'b0;

    // Stall vector: bit0 = pc, 1 = if, 2 = id, 3 = ex, 4 = mem, 5 = wb.
    // A stage stalls itself and everything upstream of it.
    localparam logic [5:0] STALL_NONE = 6'b000000;
    localparam logic [5:0] STALL_IF   = 6'b000011;
    localparam logic [5:0] STALL_ID   = 6'b000111;
    localparam logic [5:0] STALL_EX   = 6'b001111;
    localparam logic [5:0] STALL_MEM  = 6'b011111;

    typedef enum logic [1:0] {
        DIVIDLE = 2'd0,
        DIVBUSY = 2'd1,
        DIVDONE = 2'd2
    } div_state_e;

    // Result reported for a zero divisor (hi and lo both cleared).
    localparam int DIVZERO = 0;

    // Highest requesting stage wins.
    function automatic logic [5:0] stall_encode(input logic req_mem, input logic req_ex,
                                                input logic req_id, input logic req_if);
        logic [5:0] enc;
        enc = STALL_NONE;
        if (req_mem)     enc = STALL_MEM;
        else if (req_ex) enc = STALL_EX;
        else if (req_id) enc = STALL_ID;
        else if (req_if) enc = STALL_IF;
        return enc;
    endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Handshake between the pipeline controller (master) and the multi-cycle
// divider (slave).
interface pipe_ctrl_if #(
    parameter int DIV_W = 32
);
    logic               div_start;
    logic               div_annul;
    logic               div_sgn;
    logic [DIV_W-1:0]   div_a;
    logic [DIV_W-1:0]   div_b;
    logic               div_ready;
    logic [2*DIV_W-1:0] div_res;

    modport master (
        output div_start, div_annul, div_sgn, div_a, div_b,
        input  div_ready, div_res
    );

    modport slave (
        input  div_start, div_annul, div_sgn, div_a, div_b,
        output div_ready, div_res
    );
endinterface

// File: rtl/pipe_ctrl_div_seq.sv
// Divider sequencer: runs one div/divu on behalf of EX, holds the result
// until EX is allowed to move on, and aborts cleanly on a flush.
module pipe_ctrl_div_seq
    import pipe_ctrl_pkg::*;
#(
    parameter int DIV_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ex_div_req,
    input  logic               ex_div_signed,
    input  logic [DIV_W-1:0]   ex_op1,
    input  logic [DIV_W-1:0]   ex_op2,
    input  logic               flush,
    input  logic               stall_ex,
    pipe_ctrl_if.master        dbus,
    output logic [2*DIV_W-1:0] ex_div_res,
    output logic               ex_div_valid,
    output logic               div_done
);

    div_state_e state_q, state_d;
    logic       abort;
    logic       launch;
    logic       zero_div;
    logic       capture;

    // Next state. A request vanishing mid-divide means EX was squashed, so it
    // aborts exactly like a flush; abort also discards a same-cycle div_ready.
    always_comb begin
        state_d  = state_q;
        launch   = 1'b0;
        zero_div = 1'b0;
        capture  = 1'b0;
        abort    = flush || (state_q == DIVBUSY && !ex_div_req);
        if (abort) begin
            state_d = DIVIDLE;
        end else begin
            case (state_q)
                DIVIDLE: begin
                    if (ex_div_req) begin
                        if (ex_op2 != '0) begin
                            launch  = 1'b1;
                            state_d = DIVBUSY;
                        end else begin
                            zero_div = 1'b1;
                            state_d  = DIVDONE;
                        end
                    end
                end
                DIVBUSY: begin
                    if (dbus.div_ready) begin
                        capture = 1'b1;
                        state_d = DIVDONE;
                    end
                end
                DIVDONE: begin
                    if (stall_ex == NOSTOP) state_d = DIVIDLE;
                end
                default: state_d = DIVIDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= DIVIDLE;
        else      state_q <= state_d;
    end

    // Operands are frozen at launch so EX forwarding changes cannot disturb the divider.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dbus.div_a   <= '0;
            dbus.div_b   <= '0;
            dbus.div_sgn <= 1'b0;
        end else if (launch) begin
            dbus.div_a   <= ex_op1;
            dbus.div_b   <= ex_op2;
            dbus.div_sgn <= ex_div_signed;
        end
    end

    // Single-cycle start/annul pulses to the divider.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dbus.div_start <= 1'b0;
            dbus.div_annul <= 1'b0;
        end else begin
            dbus.div_start <= launch;
            dbus.div_annul <= abort && (state_q == DIVBUSY);
        end
    end

    // Result register: held through DONE while MEM keeps EX stopped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)          ex_div_res <= '0;
        else if (zero_div) ex_div_res <= (2*DIV_W)'(DIVZERO);
        else if (capture)  ex_div_res <= dbus.div_res;
    end

    assign ex_div_valid = (state_q == DIVDONE);
    assign div_done     = (state_q == DIVDONE);

endmodule

// File: rtl/pipe_ctrl.sv
// Central pipeline controller: merges stage stall requests, gates them with
// flush, sequences the divider for EX and counts stalled cycles.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int DIV_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stallreq_if,
    input  logic               stallreq_id,
    input  logic               stallreq_mem,
    input  logic               flush,
    input  logic               ex_div_req,
    input  logic               ex_div_signed,
    input  logic [DIV_W-1:0]   ex_op1,
    input  logic [DIV_W-1:0]   ex_op2,
    pipe_ctrl_if.master        dbus,
    output logic [2*DIV_W-1:0] ex_div_res,
    output logic               ex_div_valid,
    output logic [5:0]         stall,
    output logic               flush_o,
    output logic [31:0]        stall_cycles
);

    logic        div_done;
    logic        stallreq_ex;
    logic [31:0] cyc_cnt_q;

    // EX holds the pipe until the divide has produced its result.
    assign stallreq_ex = ex_div_req && !div_done;

    // Priority stall encoder; a flush overrides every stall request.
    always_comb begin
        stall   = stall_encode(stallreq_mem, stallreq_ex, stallreq_id, stallreq_if);
        flush_o = flush;
        if (flush) stall = STALL_NONE;
    end

    pipe_ctrl_div_seq #(.DIV_W(DIV_W)) u_div_seq (
        .clk          (clk),
        .rst          (rst),
        .ex_div_req   (ex_div_req),
        .ex_div_signed(ex_div_signed),
        .ex_op1       (ex_op1),
        .ex_op2       (ex_op2),
        .flush        (flush),
        .stall_ex     (stall[3]),
        .dbus         (dbus),
        .ex_div_res   (ex_div_res),
        .ex_div_valid (ex_div_valid),
        .div_done     (div_done)
    );

    // Saturating count of cycles in which the PC is held.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                                   cyc_cnt_q <= '0;
        else if (stall[0] == STOP && cyc_cnt_q != '1) cyc_cnt_q <= cyc_cnt_q + 32'd1;
    end

    assign stall_cycles = cyc_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: table vectors for the stall encoder, hand sequences for
// divider corner cases, randomized stalls and divides against a reference model.
module tb_pipe_ctrl;
    import pipe_ctrl_pkg::*;

    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           stallreq_if, stallreq_id, stallreq_mem, flush;
    logic           ex_div_req, ex_div_signed;
    logic [W-1:0]   ex_op1, ex_op2;
    logic [2*W-1:0] ex_div_res;
    logic           ex_div_valid;
    logic [5:0]     stall;
    logic           flush_o;
    logic [31:0]    stall_cycles;

    always #5 clk = ~clk;

    pipe_ctrl_if #(.DIV_W(W)) dbus ();

    pipe_ctrl #(.DIV_W(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .stallreq_if  (stallreq_if),
        .stallreq_id  (stallreq_id),
        .stallreq_mem (stallreq_mem),
        .flush        (flush),
        .ex_div_req   (ex_div_req),
        .ex_div_signed(ex_div_signed),
        .ex_op1       (ex_op1),
        .ex_op2       (ex_op2),
        .dbus         (dbus),
        .ex_div_res   (ex_div_res),
        .ex_div_valid (ex_div_valid),
        .stall        (stall),
        .flush_o      (flush_o),
        .stall_cycles (stall_cycles)
    );

    // ---------------- reference arithmetic ----------------
    function automatic logic [2*W-1:0] ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                               input logic s);
        logic [W-1:0] q, r;
        if (b == '0) return '0;
        if (s) begin
            q = W'($signed(a) / $signed(b));
            r = W'($signed(a) % $signed(b));
        end else begin
            q = a / b;
            r = a % b;
        end
        return {r, q};
    endfunction

    // Stall vector as a run of ones: if -> 2, id -> 3, ex -> 4, mem -> 5 stages held.
    function automatic logic [5:0] model_stall(input logic m, input logic e, input logic d,
                                               input logic i, input logic f);
        int n;
        n = 0;
        if (i) n = 2;
        if (d) n = 3;
        if (e) n = 4;
        if (m) n = 5;
        if (f) n = 0;
        return 6'((1 << n) - 1);
    endfunction

    // ---------------- divider model ----------------
    int             lat = 5;
    logic           mdl_rdy, stray_rdy;
    logic [2*W-1:0] mdl_res;
    int             mdl_cnt;
    bit             mdl_busy;

    assign dbus.div_ready = mdl_rdy | stray_rdy;
    assign dbus.div_res   = mdl_res;

    always @(negedge clk or negedge rst) begin
        if (!rst) begin
            mdl_rdy  = 1'b0;
            mdl_busy = 1'b0;
            mdl_cnt  = 0;
            mdl_res  = '0;
        end else begin
            mdl_rdy = 1'b0;
            if (dbus.div_annul) mdl_busy = 1'b0;
            else if (mdl_busy) begin
                mdl_cnt = mdl_cnt - 1;
                if (mdl_cnt == 0) begin
                    mdl_rdy  = 1'b1;
                    mdl_busy = 1'b0;
                end
            end
            if (dbus.div_start) begin
                mdl_busy = 1'b1;
                mdl_cnt  = lat - 1;
                mdl_res  = ref_div(dbus.div_a, dbus.div_b, dbus.div_sgn);
            end
        end
    end

    // ---------------- checking ----------------
    int          n_cmp = 0;
    int          n_bad = 0;
    logic        exp_ex = 1'b0;
    logic [31:0] exp_cnt = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_stall(input string name);
        chk(name, 64'(stall), 64'(model_stall(stallreq_mem, exp_ex, stallreq_id, stallreq_if, flush)));
        chk({name, " flush_o"}, 64'(flush_o), 64'(flush));
    endtask

    // Advance one cycle, tracking the expected stall counter.
    task automatic step();
        if (rst && model_stall(stallreq_mem, exp_ex, stallreq_id, stallreq_if, flush) != 6'd0
            && exp_cnt != 32'hFFFF_FFFF)
            exp_cnt = exp_cnt + 32'd1;
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        stallreq_if = 1'b0; stallreq_id = 1'b0; stallreq_mem = 1'b0; flush = 1'b0;
        ex_div_req = 1'b0; exp_ex = 1'b0; stray_rdy = 1'b0;
    endtask

    // One divide issued from IDLE, optionally held in DONE by MEM for memhold cycles.
    task automatic do_div(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic s, input int l, input int memhold);
        int             nex, starts;
        logic [2*W-1:0] er;
        nex    = (b == '0) ? 1 : l + 1;
        er     = ref_div(a, b, s);
        lat    = l;
        starts = 0;
        ex_div_req = 1'b1; ex_op1 = a; ex_op2 = b; ex_div_signed = s;
        for (int c = 0; c < nex + memhold + 1; c++) begin
            exp_ex       = (c < nex);
            stallreq_mem = (c >= nex && c < nex + memhold);
            @(negedge clk);
            chk_stall({name, " stall"});
            if (dbus.div_start) begin
                starts++;
                chk({name, " div_a"},   64'(dbus.div_a),   64'(a));
                chk({name, " div_b"},   64'(dbus.div_b),   64'(b));
                chk({name, " div_sgn"}, 64'(dbus.div_sgn), 64'(s));
            end
            if (c < nex) chk({name, " valid early"}, 64'(ex_div_valid), 64'd0);
            else begin
                chk({name, " valid"}, 64'(ex_div_valid), 64'd1);
                chk({name, " result"}, ex_div_res, er);
            end
            step();
        end
        ex_div_req = 1'b0; stallreq_mem = 1'b0; exp_ex = 1'b0;
        @(negedge clk);
        chk({name, " valid after"}, 64'(ex_div_valid), 64'd0);
        chk({name, " start count"}, 64'(starts), (b == '0) ? 64'd0 : 64'd1);
        chk_stall({name, " idle stall"});
        step();
    endtask

    typedef struct {
        logic       m, d, i, f;
        logic [5:0] es;
    } vec_t;

    vec_t tbl [9];

    initial begin
        tbl = '{
            '{1'b0, 1'b0, 1'b0, 1'b0, 6'b000000},
            '{1'b0, 1'b0, 1'b1, 1'b0, 6'b000011},
            '{1'b0, 1'b1, 1'b0, 1'b0, 6'b000111},
            '{1'b0, 1'b1, 1'b1, 1'b0, 6'b000111},
            '{1'b1, 1'b1, 1'b1, 1'b0, 6'b011111},
            '{1'b1, 1'b0, 1'b0, 1'b0, 6'b011111},
            '{1'b1, 1'b0, 1'b1, 1'b0, 6'b011111},
            '{1'b1, 1'b1, 1'b1, 1'b1, 6'b000000},
            '{1'b0, 1'b1, 1'b0, 1'b1, 6'b000000}
        };
        quiet();
        ex_div_signed = 1'b0; ex_op1 = '0; ex_op2 = '0;

        // Reset state
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst stall",     64'(stall),          64'd0);
        chk("rst flush_o",   64'(flush_o),        64'd0);
        chk("rst div_start", 64'(dbus.div_start), 64'd0);
        chk("rst div_annul", 64'(dbus.div_annul), 64'd0);
        chk("rst div_a",     64'(dbus.div_a),     64'd0);
        chk("rst div_b",     64'(dbus.div_b),     64'd0);
        chk("rst div_sgn",   64'(dbus.div_sgn),   64'd0);
        chk("rst res",       ex_div_res,          64'd0);
        chk("rst valid",     64'(ex_div_valid),   64'd0);
        chk("rst cycles",    64'(stall_cycles),   64'd0);
        rst = 1'b1;
        step();

        // Stall encoder vectors
        foreach (tbl[k]) begin
            stallreq_mem = tbl[k].m; stallreq_id = tbl[k].d;
            stallreq_if  = tbl[k].i; flush = tbl[k].f;
            @(negedge clk);
            chk($sformatf("vec%0d stall", k),   64'(stall),   64'(tbl[k].es));
            chk($sformatf("vec%0d flush_o", k), 64'(flush_o), 64'(tbl[k].f));
            step();
        end
        quiet();
        @(negedge clk);
        chk("cycles after vectors", 64'(stall_cycles), 64'(exp_cnt));
        step();

        // Directed divides
        do_div("divu 100/7", 32'd100, 32'd7, 1'b0, 5, 0);
        do_div("div by zero", 32'd55, 32'd0, 1'b1, 5, 0);
        do_div("div mem hold", 32'hFFFF_FFCE, 32'd7, 1'b1, 3, 3);

        // Flush in the third BUSY cycle
        lat = 8; ex_div_req = 1'b1; ex_op1 = 32'd900; ex_op2 = 32'd9; ex_div_signed = 1'b0;
        exp_ex = 1'b1;
        for (int c = 0; c < 8; c++) begin
            flush     = (c == 3);
            stray_rdy = (c == 3 || c == 6);
            if (c == 4) begin ex_div_req = 1'b0; exp_ex = 1'b0; end
            @(negedge clk);
            chk_stall($sformatf("flush c%0d", c));
            if (c == 1) chk("flush start", 64'(dbus.div_start), 64'd1);
            if (c >= 4) chk($sformatf("flush annul c%0d", c), 64'(dbus.div_annul), (c == 4) ? 64'd1 : 64'd0);
            if (c >= 4) chk($sformatf("flush valid c%0d", c), 64'(ex_div_valid), 64'd0);
            step();
        end
        quiet();

        // Request dropped mid-divide acts as a flush
        lat = 8; ex_div_req = 1'b1; ex_op1 = 32'd50; ex_op2 = 32'd5; exp_ex = 1'b1;
        step(); step();
        ex_div_req = 1'b0; exp_ex = 1'b0;
        @(negedge clk);
        chk_stall("drop stall");
        step();
        @(negedge clk);
        chk("drop annul", 64'(dbus.div_annul), 64'd1);
        chk("drop valid", 64'(ex_div_valid),   64'd0);
        step();
        step();

        // Counter saturation from a preloaded value
        force dut.cyc_cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.cyc_cnt_q;
        exp_cnt = 32'hFFFF_FFFE;
        stallreq_if = 1'b1;
        repeat (4) step();
        stallreq_if = 1'b0;
        @(negedge clk);
        chk("cycles saturate", 64'(stall_cycles), 64'(exp_cnt));
        step();

        // Async reset in the middle of BUSY
        lat = 8; ex_div_req = 1'b1; ex_op1 = 32'd77; ex_op2 = 32'd3; exp_ex = 1'b1;
        step(); step();
        #2;
        rst = 1'b0; ex_div_req = 1'b0; exp_ex = 1'b0; exp_cnt = '0;
        #1;
        chk("arst stall",   64'(stall),          64'd0);
        chk("arst start",   64'(dbus.div_start), 64'd0);
        chk("arst annul",   64'(dbus.div_annul), 64'd0);
        chk("arst div_a",   64'(dbus.div_a),     64'd0);
        chk("arst div_b",   64'(dbus.div_b),     64'd0);
        chk("arst res",     ex_div_res,          64'd0);
        chk("arst valid",   64'(ex_div_valid),   64'd0);
        chk("arst cycles",  64'(stall_cycles),   64'd0);
        @(negedge clk);
        rst = 1'b1;
        step();
        do_div("after reset", 32'd1000, 32'd33, 1'b0, 4, 1);

        // Random stall requests
        for (int k = 0; k < 120; k++) begin
            stallreq_if  = 1'($urandom_range(0, 1));
            stallreq_id  = 1'($urandom_range(0, 1));
            stallreq_mem = ($urandom_range(0, 3) == 0);
            flush        = ($urandom_range(0, 7) == 0);
            @(negedge clk);
            chk_stall("rand stall");
            step();
        end
        quiet();
        @(negedge clk);
        chk("cycles after random", 64'(stall_cycles), 64'(exp_cnt));
        step();

        // Random divides
        for (int k = 0; k < 10; k++) begin
            logic [W-1:0] a, b;
            logic         s;
            a = $urandom;
            case ($urandom_range(0, 3))
                0:       b = '0;
                1:       b = $urandom;
                default: b = $urandom_range(1, 1000);
            endcase
            s = 1'($urandom_range(0, 1));
            if (s && b == 32'hFFFF_FFFF) b = 32'd3;
            do_div($sformatf("rand div%0d", k), a, b, s, $urandom_range(2, 7), $urandom_range(0, 3));
        end
        @(negedge clk);
        chk("cycles final", 64'(stall_cycles), 64'(exp_cnt));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Central pipeline controller for the five-stage MIPS core. It merges per-stage stall requests into the 6-bit `stall` vector consumed by every pipeline register, including EX/MEM and MEM/WB. It also sequences the multi-cycle divider on behalf of EX and counts pipeline stall cycles. It sits beside the datapath, between the stage request sources and the pipeline registers.

## Interface
Parameters:
- `DIV_W`, default 32: divider operand width.

Ports:
- `clk`  in  1  core clock
- `rst`  in  1  reset, asynchronous, active-low
- `stallreq_if`  in  1  instruction fetch wait
- `stallreq_id`  in  1  load-use hazard
- `stallreq_mem`  in  1  data memory wait
- `flush`  in  1  exception flush, one-cycle pulse
- `ex_div_req`  in  1  EX holds a div/divu
- `ex_div_signed`  in  1  1 = div, 0 = divu
- `ex_op1`, `ex_op2`  in  DIV_W  dividend, divisor
- `div_ready`  in  1  divider result valid, one-cycle pulse
- `div_res`  in  2*DIV_W  {remainder, quotient} from the divider
- `div_start`  out  1  start pulse to the divider
- `div_annul`  out  1  abort pulse to the divider
- `div_a`, `div_b`  out  DIV_W  latched operands
- `div_sgn`  out  1  latched signed flag
- `ex_div_res`  out  2*DIV_W  {hi, lo} result to EX
- `ex_div_valid`  out  1  result valid for EX
- `stall`  out  6  bit0 = pc, bit1 = if, bit2 = id, bit3 = ex, bit4 = mem, bit5 = wb; 1 = STOP
- `flush_o`  out  1  flush to all pipeline registers
- `stall_cycles`  out  32  performance counter

## Operation
- Stall vector, evaluated combinationally with the highest stage winning:
  - `stallreq_mem`: 011111
  - EX request (`stallreq_ex`): 001111
  - `stallreq_id`: 000111
  - `stallreq_if`: 000011
  - none: 000000
- `stallreq_ex` is internal: it is 1 when `ex_div_req` is high and the FSM is not in DONE.
- `flush`: `stall` is forced to 000000 and `flush_o` = 1 in the same cycle.
- Divider FSM, states IDLE, BUSY, DONE:
  - IDLE, `ex_div_req` = 1, `ex_op2` != 0: latch operands and sign, assert `div_start` for one cycle (registered), go to BUSY.
  - IDLE, `ex_div_req` = 1, `ex_op2` == 0: load `ex_div_res` = 0 and go to DONE. The divider is not started.
  - BUSY, `div_ready` = 1: capture `div_res` into `ex_div_res`, go to DONE.
  - DONE: `ex_div_valid` = 1. Leave for IDLE at the edge where `stall[3]` = 0. While a MEM stall holds `stall[3]` = 1, remain in DONE with the result held.
  - `flush` in any state: go to IDLE next edge. If the state was BUSY, pulse `div_annul` for one cycle. A `div_ready` arriving in the flush cycle is discarded.
  - `ex_div_req` dropping while in BUSY (never legal without `flush`): treated as `flush`.
- `stall_cycles` increments each cycle `stall[0]` = 1 and saturates at 0xFFFFFFFF.

## Timing
- Reset values, applied asynchronously while `rst` = 0:
  - FSM = IDLE
  - `div_start`, `div_annul`, `ex_div_valid` = 0
  - `div_a`, `div_b`, `ex_div_res`, `stall_cycles` = 0
  - `div_sgn` = 0
  - `stall`, `flush_o` = 0, because the requests are also quiet in reset
- `stall` and `flush_o` have zero latency from their inputs.
- `div_start` is asserted one cycle after `ex_div_req` is first seen in IDLE.
- Divide-by-zero completes in 1 cycle, with `ex_div_valid` in the next cycle.
- Minimum EX occupancy for a divide: divider latency + 2 cycles.
- `div_ready` outside BUSY is ignored.
- A reset deasserted mid-operation restarts in IDLE. The divider must also be reset by the same `rst`.

## Structure
- `macro.v` gains:
  - `STOP` / `NOSTOP`
  - the five stall encodings
  - FSM state codes `DIVIDLE`, `DIVBUSY`, `DIVDONE`
  - `DIVZERO` result constant
- Sub-module `div_seq`: FSM, operand and result registers, and start/annul generation.
- The top level holds the stall priority encoder, flush gating and the performance counter.

## Test plan
- `stallreq_id` = 1 with `stallreq_if` = 1 -> `stall` = 000111. Add `stallreq_mem` = 1 -> 011111.
- divu 100/7, divider ready after 5 cycles:
  - `div_start` pulses once, with `div_a` = 100 and `div_b` = 7
  - `stall` = 001111 for 6 cycles
  - `ex_div_res` = {2, 14}, `ex_div_valid` for 1 cycle
- div with `ex_op2` = 0 -> no `div_start`, `ex_div_res` = 0, EX stalled exactly 1 cycle.
- `flush` in the 3rd BUSY cycle -> `div_annul` pulses 1 cycle, FSM in IDLE, later `div_ready` ignored, `stall` = 0.
- In DONE with `stallreq_mem` = 1 for 3 cycles -> result held and `ex_div_valid` stays 1. FSM returns to IDLE once `stall[3]` = 0.
- Preload `stall_cycles` = 0xFFFFFFFE, stall 4 cycles -> counter = 0xFFFFFFFF. Async `rst` low mid-BUSY -> all outputs zero immediately.
